mul_div_unit: RTL and testbench

//  Multi-cycle integer multiply/divide unit for the EX stage, alongside the ALU.
//  It takes the same A/B operands as the ALU and owns the architectural HI/LO registers.
//  Ops: MULT, MULTU, DIV, DIVU, MTHI, MTLO. MFHI/MFLO read hi/lo ports directly.

---
 rtl/mul_div_unit_if.sv | 25 ++
 rtl/mul_div_unit.sv | 132 +++++++++++++
 tb/tb_mul_div_unit.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/mul_div_unit_if.sv
// Handshake and result bundle between the EX stage and the multiply/divide unit.
// The EX stage drives the master side; mul_div_unit uses the slave side.
interface mul_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, A, B, flush,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, A, B, flush,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit owning HI/LO. Shift-add multiply and restoring
// divide run on magnitudes, one bit per cycle; signs are applied in FIX.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  mul_div_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             r_state;
  logic [CW-1:0]      r_count;
  logic               r_busy;
  logic               r_done;
  logic               r_fix_ph;
  logic               r_is_div;
  logic               r_neg_res;
  logic               r_neg_rem;
  logic               r_div0;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [2*WIDTH-1:0] r_acc;

  logic               w_sgn;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WIDTH:0]     w_msum;
  logic [WIDTH:0]     w_dtrial;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [2*WIDTH-1:0] w_div_next;
  logic [2*WIDTH-1:0] w_fixed;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
    return (sgn && x[WIDTH-1]) ? (~x + WIDTH'(1)) : x;
  endfunction

  assign w_sgn   = ~bus.op[0];
  assign w_abs_a = mag(bus.A, w_sgn);
  assign w_abs_b = mag(bus.B, w_sgn);

  // Multiply: acc = {partial product, remaining multiplier bits}; r_b holds the multiplicand.
  assign w_msum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : '0);
  assign w_mul_next = {w_msum, r_acc[WIDTH-1:1]};

  // Divide: acc = {partial remainder, dividend bits / quotient bits}; r_b holds the divisor.
  assign w_dtrial   = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_b};
  assign w_div_next = w_dtrial[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                      : {w_dtrial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

  always_comb begin
    w_fixed = r_acc;
    if (!r_is_div) begin
      if (r_neg_res) w_fixed = -r_acc;
    end else begin
      w_fixed[2*WIDTH-1:WIDTH] = r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
      if (r_div0)         w_fixed[WIDTH-1:0] = '1;
      else if (r_neg_res) w_fixed[WIDTH-1:0] = -r_acc[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_count  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_fix_ph <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_done <= 1'b0;
      if (bus.flush) begin
        r_state  <= IDLE;
        r_busy   <= 1'b0;
        r_fix_ph <= 1'b0;
      end else begin
        case (r_state)
          IDLE: if (bus.start) begin
            case (bus.op)
              3'b000, 3'b001, 3'b010, 3'b011: begin
                r_is_div  <= bus.op[1];
                r_neg_res <= w_sgn & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
                r_neg_rem <= w_sgn & bus.A[WIDTH-1];
                r_div0    <= (bus.B == '0);
                r_b       <= bus.op[1] ? w_abs_b : w_abs_a;
                r_acc     <= {{WIDTH{1'b0}}, (bus.op[1] ? w_abs_a : w_abs_b)};
                r_count   <= '0;
                r_busy    <= 1'b1;
                r_state   <= CALC;
              end
              3'b100:  r_hi <= bus.A;
              3'b101:  r_lo <= bus.A;
              default: ;
            endcase
          end
          CALC: begin
            r_acc   <= r_is_div ? w_div_next : w_mul_next;
            r_count <= r_count + CW'(1);
            if (r_count == CW'(WIDTH-1)) begin
              r_state  <= FIX;
              r_fix_ph <= 1'b0;
            end
          end
          FIX: begin
            // First FIX cycle corrects signs and releases busy; second publishes HI/LO with done.
            if (!r_fix_ph) begin
              r_acc    <= w_fixed;
              r_busy   <= 1'b0;
              r_fix_ph <= 1'b1;
            end else begin
              r_hi     <= r_acc[2*WIDTH-1:WIDTH];
              r_lo     <= r_acc[WIDTH-1:0];
              r_done   <= 1'b1;
              r_fix_ph <= 1'b0;
              r_state  <= IDLE;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed plus randomized bench for mul_div_unit against a 64-bit arithmetic
// reference model; tracks the architectural HI/LO state independently.
module tb_mul_div_unit;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  mul_div_unit_if #(.WIDTH(32)) bus ();

  mul_div_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, q, rm;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = '0;
    case (o)
      3'd0: r = 64'(sa * sb);
      3'd1: r = {32'b0, a} * {32'b0, b};
      3'd2: begin
        if (b == 32'd0) r = {a, 32'hFFFFFFFF};
        else begin
          q  = sa / sb;
          rm = sa % sb;
          r  = {rm[31:0], q[31:0]};
        end
      end
      3'd3: begin
        if (b == 32'd0) r = {a, 32'hFFFFFFFF};
        else            r = {a % b, a / b};
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  // Issues one mul/div op and returns in the done cycle so a following call is back-to-back.
  task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input bit intrude);
    logic [63:0] exp;
    int e, busy_cnt;
    bit got;
    exp = model(o, a, b);
    bus.start = 1'b1; bus.op = o; bus.A = a; bus.B = b;
    tick();
    bus.start = 1'b0;
    e = 0; busy_cnt = 0; got = 1'b0;
    while (!got && e < 40) begin
      if (bus.busy) busy_cnt++;
      if (bus.done) got = 1'b1;
      else begin
        if (intrude && e == 4) begin
          bus.start = 1'b1; bus.op = 3'd3; bus.A = 32'd100; bus.B = 32'd7;
        end
        tick();
        bus.start = 1'b0;
        e++;
      end
    end
    chk({tag, "_latency"}, 64'(e), 64'd34);
    chk({tag, "_busycyc"}, 64'(busy_cnt), 64'd33);
    chk({tag, "_hi"}, {32'b0, bus.hi}, {32'b0, exp[63:32]});
    chk({tag, "_lo"}, {32'b0, bus.lo}, {32'b0, exp[31:0]});
    exp_hi = exp[63:32];
    exp_lo = exp[31:0];
  endtask

  task automatic do_mt(input string tag, input bit to_lo, input logic [31:0] a);
    bus.start = 1'b1; bus.op = to_lo ? 3'd5 : 3'd4; bus.A = a; bus.B = $urandom;
    tick();
    bus.start = 1'b0;
    if (to_lo) exp_lo = a;
    else       exp_hi = a;
    chk({tag, "_done"}, {62'b0, bus.done, bus.busy}, 64'd0);
    chk({tag, "_hilo"}, {bus.hi, bus.lo}, {exp_hi, exp_lo});
  endtask

  initial begin
    logic [2:0]  o;
    logic [31:0] a, b;
    int          sel;
    bit          seen_done;
    checks = 0; errors = 0;
    exp_hi = '0; exp_lo = '0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.op = '0; bus.A = '0; bus.B = '0; bus.flush = 1'b0;
    tick(); tick();
    chk("reset_state", {60'b0, bus.busy, bus.done, 2'b0}, 64'd0);
    chk("reset_hilo", {bus.hi, bus.lo}, 64'd0);
    rst_n = 1'b1;
    tick();

    do_op("multu_max", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    chk("multu_max_const", {bus.hi, bus.lo}, 64'hFFFFFFFE_00000001);
    do_op("mult_neg", 3'd0, 32'hFFFFFFFB, 32'h7, 1'b0);
    chk("mult_neg_const", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFDD);
    do_op("div_neg", 3'd2, 32'hFFFFFFF9, 32'h2, 1'b0);
    chk("div_neg_const", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFFD);
    do_op("divu", 3'd3, 32'h7, 32'h2, 1'b0);
    chk("divu_const", {bus.hi, bus.lo}, 64'h00000001_00000003);
    do_op("div_zero", 3'd2, 32'h12345678, 32'h0, 1'b0);
    chk("div_zero_const", {bus.hi, bus.lo}, 64'h12345678_FFFFFFFF);
    do_op("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    chk("div_ovf_const", {bus.hi, bus.lo}, 64'h00000000_80000000);
    do_op("start_busy", 3'd1, 32'd3, 32'd4, 1'b1);
    chk("start_busy_const", {bus.hi, bus.lo}, 64'd12);

    tick();
    bus.start = 1'b1; bus.op = 3'd6; bus.A = 32'hDEADBEEF;
    tick();
    bus.start = 1'b0;
    chk("undef_op", {bus.hi, bus.lo, 30'b0, bus.busy, bus.done}, {exp_hi, exp_lo, 32'b0});

    do_mt("mthi", 1'b0, 32'hCAFEF00D);
    do_mt("mtlo", 1'b1, 32'h0BADC0DE);

    // Flush at edge 10 of a DIVU: no result, HI/LO keep the MTHI/MTLO values.
    bus.start = 1'b1; bus.op = 3'd3; bus.A = 32'd1000; bus.B = 32'd3;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    chk("flush_pre_busy", {63'b0, bus.busy}, 64'd1);
    bus.flush = 1'b1; bus.start = 1'b1;
    tick();
    bus.flush = 1'b0; bus.start = 1'b0;
    chk("flush_busy", {62'b0, bus.busy, bus.done}, 64'd0);
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done || bus.busy) seen_done = 1'b1;
      tick();
    end
    chk("flush_no_done", {63'b0, seen_done}, 64'd0);
    chk("flush_hilo", {bus.hi, bus.lo}, {exp_hi, exp_lo});

    // Reset asserted at edge 5 of a MULT.
    bus.start = 1'b1; bus.op = 3'd0; bus.A = 32'h1234; bus.B = 32'h5678;
    tick();
    bus.start = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_hi = '0; exp_lo = '0;
    chk("midop_reset", {bus.hi, bus.lo, 30'b0, bus.busy, bus.done}, 96'b0);
    tick();

    for (int n = 0; n < 200; n++) begin
      o   = 3'($urandom_range(0, 3));
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) b = 32'd0;
      else if (sel == 1) b = 32'($urandom_range(1, 15));
      else if (sel == 2) b = 32'hFFFFFFFF;
      else if (sel == 3) a = 32'h80000000;
      do_op("rand", o, a, b, 1'b0);
      if ((n % 25) == 7) begin
        do_mt("rand_mthi", 1'b0, $urandom);
        do_mt("rand_mtlo", 1'b1, $urandom);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
